// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write-back buffer in front of the register file, with read-hazard detection and youngest-entry forwarding
// Ports:
//   CLK, Reset_n                  clock, asynchronous active-low reset
//   InValid/InReady/InData/InAddr write-request handshake from execute/memory
//   Hold                          stalls draining; pushes still accepted
//   DataIn/Write/WriteAddr        register-file write port, one pop per cycle
//   ReadAddrA/B                   register-file read addresses to check
//   HazardA/B, FwdDataA/B         pending-write match and youngest matching data
//   Level                         number of entries held
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [DATA_W-1:0]        InData,
    input  logic [ADDR_W-1:0]        InAddr,
    input  logic                     Hold,
    output logic [DATA_W-1:0]        DataIn,
    output logic                     Write,
    output logic [ADDR_W-1:0]        WriteAddr,
    input  logic [ADDR_W-1:0]        ReadAddrA,
    input  logic [ADDR_W-1:0]        ReadAddrB,
    output logic                     HazardA,
    output logic                     HazardB,
    output logic [DATA_W-1:0]        FwdDataA,
    output logic [DATA_W-1:0]        FwdDataB,
    output logic [$clog2(DEPTH):0]   Level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [PW-1:0] head, tail;
    logic push, notEmpty;
    assign notEmpty  = Level != '0;
    assign InReady   = Reset_n && (Level != LW'(DEPTH));
    assign push      = InValid && InReady;
    assign Write     = notEmpty && !Hold;
    assign DataIn    = notEmpty ? dataMem[head] : '0;
    assign WriteAddr = notEmpty ? addrMem[head] : '0;
    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        HazardA  = 1'b0;
        HazardB  = 1'b0;
        FwdDataA = '0;
        FwdDataB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LW'(i) < Level && addrMem[head + PW'(i)] == ReadAddrA) begin
                HazardA  = 1'b1;
                FwdDataA = dataMem[head + PW'(i)];
            end
            if (LW'(i) < Level && addrMem[head + PW'(i)] == ReadAddrB) begin
                HazardB  = 1'b1;
                FwdDataB = dataMem[head + PW'(i)];
            end
        end
    end
    // Storage needs no reset: entries are only observed while Level covers them.
    always_ff @(posedge CLK) begin
        if (push) begin
            dataMem[tail] <= InData;
            addrMem[tail] <= InAddr;
        end
    end
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            head  <= '0;
            tail  <= '0;
            Level <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (Write) head <= head + PW'(1);
            Level <= Level + LW'(push) - LW'(Write);
        end
    end
endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-back buffer placed directly upstream of the 8 x 16-bit register file. It accepts register-write requests from the execute/memory stages over a valid/ready handshake, holds up to DEPTH of them in order, and drains one per clock into the register file's DataIn/Write/WriteAddr port. It also checks the two register-file read addresses against pending writes, flagging hazards and supplying the youngest pending data for forwarding.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- DATA_W, 16, data width; matches register file
- ADDR_W, 3, register address width; matches register file
- CLK  in  1  clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- InValid  in  1  write request present
- InReady  out  1  queue can accept a request this cycle
- InData  in  DATA_W  write data
- InAddr  in  ADDR_W  destination register
- Hold  in  1  suppress draining while high; pushes are still accepted
- DataIn  out  DATA_W  to register file data input
- Write  out  1  to register file write enable
- WriteAddr  out  ADDR_W  to register file write address
- ReadAddrA, ReadAddrB  in  ADDR_W  the same addresses driven to the register file read ports
- HazardA, HazardB  out  1  a pending entry targets that read address
- FwdDataA, FwdDataB  out  DATA_W  data of the youngest pending entry matching that address
- Level  out  clog2(DEPTH)+1  current number of entries

## Operation
- Circular FIFO with head/tail pointers that wrap modulo DEPTH, plus an occupancy counter of 0..DEPTH.
- Push occurs when InValid && InReady at a rising edge. The entry {InAddr, InData} is stored at tail, and tail advances.
- InReady = Reset_n && (Level != DEPTH). There is no pass-through when full.
- Drain: Write = (Level != 0) && !Hold. DataIn and WriteAddr show the head entry while Level != 0, and are 0 when empty.
- Pop occurs at every edge where Write = 1. The register file captures the head at the same edge, and head advances.
- Simultaneous push and pop leaves Level unchanged. Both pointers advance.
- Entries are never reordered or merged. Duplicate addresses are all written, oldest first.
- Hazard check: each valid entry, including the head being written this cycle, is compared against ReadAddrA and ReadAddrB.
  - HazardX = 1 if any entry matches.
  - FwdDataX = InData of the matching entry nearest the tail, i.e. the youngest.
  - FwdDataX = 0 when there is no match.
- Hazard outputs are combinational from the stored state and the read addresses. Incoming InData/InAddr do not participate.
- Register 0 is an ordinary register and has no special case.

## Timing
- Reset (Reset_n low, asynchronous): pointers = 0, Level = 0, all entries invalidated.
- Output values during and after reset: Write = 0, DataIn = 0, WriteAddr = 0, HazardA/B = 0, FwdDataA/B = 0, InReady = 0 while reset is asserted and 1 after release.
- Latency: a request accepted at edge N appears on Write/DataIn/WriteAddr during cycle N..N+1 and is written into the register file at edge N+1, provided the queue was empty and Hold = 0.
- Throughput: one push and one pop per cycle.
- Full: InReady falls immediately after the edge that makes Level = DEPTH. It rises in the cycle after the first pop.
- Empty: Write = 0 and hazards are 0. A push to an empty queue is visible to the hazard logic from the next cycle.
- Hold asserted mid-stream: Write drops in the same cycle and the head is retained. Hold released: draining resumes in the same cycle.
- Reset mid-operation: all pending entries are discarded and no further writes are issued from them.
- Pointer wrap: behaviour is identical across the DEPTH-1 -> 0 boundary.

## Test plan
- Reset: with Reset_n low, Write = 0, InReady = 0, Level = 0. After release, InReady = 1.
- Single write: push addr 3, data 16'h0003 into an empty queue with Hold = 0.
  - Next cycle: Write = 1, WriteAddr = 3, DataIn = 16'h0003, HazardA = 1 with ReadAddrA = 3.
  - Following cycle: Level = 0 and the register file reads back 16'h0003.
- Fill and stall: with Hold = 1, push addrs 0,1,2,3 with data 16'hFFFF, 1, 2, 3.
  - After the 4th edge: Level = 4, InReady = 0, and a 5th InValid is not accepted.
  - Release Hold: writes issue in order 0,1,2,3 on four consecutive edges, and InReady returns after the first.
- Forwarding priority: with Hold = 1, push addr 5 data 16'h0005, then addr 5 data 16'h00AA.
  - ReadAddrB = 5 gives HazardB = 1, FwdDataB = 16'h00AA.
  - ReadAddrA = 6 gives HazardA = 0, FwdDataA = 0.
- Streaming wrap: push 10 back-to-back requests (addr i mod 8, data i) with Hold = 0.
  - Level stays at 1.
  - Ten consecutive writes occur in order, with no drop or duplicate across pointer wrap.
- Reset mid-operation: with 3 entries pending and Hold = 1, pulse Reset_n low between edges.
  - Level = 0 and Hazards = 0 immediately.
  - After Hold is released, no write is issued.
